mdio_phy_cfg: RTL
=================

// Module: mdio_phy_cfg
// PURPOSE
// - Bring-up controller for the external RGMII PHY. Holds the PHY in reset, releases it, then writes a fixed
//   clause-22 MDIO register table (RGMII TX/RX clock delays). It then polls BMSR for link status.
// - Sits beside the RGMII MAC on the 125MHz local TX clock; drives phyRstBOut and the mdClk/mdio pins
//   (mdio via top-level IOBUF).
// PARAMETERS
// - CLK_DIV      25        clkIn cycles per MDC half-period (125MHz -> 2.5MHz MDC); must be >= 2
// - PHY_ADDR     5'h01     MDIO PHY address
// - RST_HOLD_CYC 1250000   cycles phyRstBOut held low (10ms @125MHz)
// - RST_WAIT_CYC 6250000   cycles after reset release before first frame (50ms)
// - POLL_CYC     12500000  cycles between BMSR polls (100ms)
// PORTS
// - clkIn        in  1   125MHz clock
// - rstBIn       in  1   async active-low reset
// - lockedIn     in  1   MMCM locked; sequence leaves IDLE only when high
// - restartIn    in  1   1-cycle pulse: rerun full sequence from PHY reset
// - phyRstBOut   out 1   PHY hardware reset, active low
// - mdClkOut     out 1   MDC
// - mdioOut      out 1   MDIO output data
// - mdioOeOut    out 1   MDIO output enable (1 = FPGA drives)
// - mdioIn       in  1   MDIO pin input
// - cfgDoneOut   out 1   table written; held until restart/reset
// - linkUpOut    out 1   BMSR[2] from most recent poll
// - errOut       out 1   sticky: read TA bit != 0, or readback mismatch (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: phyRstBOut=0, mdClkOut=0, mdioOut=1, mdioOeOut=0. cfgDoneOut, linkUpOut and errOut = 0. FSM=IDLE.
// - Config ROM (4 entries, {reg, data}):
//   - 0: 0x1F=0x0D08
//   - 1: 0x11=0x0109 (TXDLY)
//   - 2: 0x15=0x0019 (RXDLY)
//   - 3: 0x1F=0x0000
// - FSM:
//   - IDLE -> RST_HOLD when lockedIn.
//   - RST_HOLD: phyRstBOut=0 for RST_HOLD_CYC -> RST_WAIT.
//   - RST_WAIT: phyRstBOut=1 for RST_WAIT_CYC -> WR (idx=0).
//   - WR: one write frame for ROM[idx]. idx<3 -> WR (idx+1). idx==3 -> cfgDoneOut=1, POLL_WAIT.
//   - POLL_WAIT: POLL_CYC cycles -> RD (reg 0x01).
//   - RD: read frame. On completion linkUpOut<=rdData[2] -> POLL_WAIT.
// - Frame: 64 MDC periods. Bit order, MSB first:
//   - 32x'1' preamble, ST=01.
//   - OP: 01 write / 10 read.
//   - PHYAD[4:0], REGAD[4:0].
//   - TA: write drives 10; read releases both TA bits.
//   - 16 data bits.
// - MDC: divider counter toggles mdClkOut every CLK_DIV cycles, free-running only while a frame is active.
//   Frame ends with mdClkOut=0.
// - FPGA updates mdioOut/mdioOeOut on the cycle mdClkOut falls; first bit is driven one half-period before
//   the first rising edge.
// - Reads: mdioOeOut=0 from the first TA bit through the end of data. mdioIn is sampled on the clkIn cycle
//   before each MDC rising edge.
//   - TA bit 2 sampled !=0 -> errOut<=1; frame still completes.
// - Between frames: mdioOeOut=0, mdioOut=1, at least 1 MDC-period idle gap.
// - restartIn in any state: abort frame immediately. Then mdioOeOut=0, mdClkOut=0, cfgDoneOut=0, linkUpOut=0
//   -> RST_HOLD. errOut is kept.
// - lockedIn falling: same abort but -> IDLE with phyRstBOut=0.
// - rstBIn assert mid-frame: all outputs to reset values asynchronously.
// CONFIGURATION
// - MDIO_READBACK_EN defined:
//   - After each WR, issue RD of same reg.
//   - Mismatch vs ROM data -> errOut<=1; one retry of the write+read, then continue to next entry.
//   - Entries 0 and 3 (page select) are excluded.
// - Not defined: writes unverified; errOut only reflects TA errors.
// TESTING
// - Small params (CLK_DIV=2, RST_HOLD_CYC=20, RST_WAIT_CYC=30, POLL_CYC=100).
// - T1: rstBIn release, lockedIn=1 -> phyRstBOut low 20 cycles then high; first MDC edge 30 cycles later.
//   Then 4 write frames captured by MDIO slave model: (0x1F,0x0D08), (0x11,0x0109), (0x15,0x0019), (0x1F,0x0000).
//   cfgDoneOut=1 after the 4th.
// - T2: model returns BMSR=0x796D -> linkUpOut=1. Next poll returns 0x7969 -> linkUpOut=0. Polls spaced
//   >=100 cycles.
// - T3: check frame bits: 32 ones, 0101, 00001, reg, 10, data. MDC period 4 cycles. mdioOut stable across
//   every MDC rising edge.
// - T4: read where model drives TA bit2=1 -> errOut=1 sticky, FSM continues polling.
// - T5: restartIn mid 2nd write frame -> mdioOeOut=0 next cycle, cfgDoneOut=0, full sequence reruns.
//   lockedIn low -> IDLE, phyRstBOut=0.
// - T6 (MDIO_READBACK_EN): model corrupts first 0x11 write -> errOut=1, retry seen, 0x15 frame follows.

Source files
------------

// File: rtl/mdio_phy_cfg.sv
// mdio_phy_cfg
//   Bring-up controller for the external RGMII PHY. Holds the PHY in hardware
//   reset, releases it, writes a fixed clause-22 register table (RGMII TX/RX
//   clock delays) over MDIO, then polls BMSR periodically for link status.
//
// Ports
//   clkIn       125 MHz local clock
//   rstBIn      async active-low reset
//   lockedIn    MMCM locked; sequence leaves IDLE only while high, drop aborts to IDLE
//   restartIn   1-cycle pulse, aborts and reruns the sequence from PHY reset
//   phyRstBOut  PHY hardware reset, active low
//   mdClkOut    MDC
//   mdioOut     MDIO output data
//   mdioOeOut   MDIO output enable (1 = FPGA drives)
//   mdioIn      MDIO pin input
//   cfgDoneOut  register table written; cleared by restart/lock loss/reset
//   linkUpOut   BMSR[2] from the most recent poll
//   errOut      sticky error: read TA bit 2 non-zero, or readback mismatch
//
// Build option
//   MDIO_READBACK_EN  when defined, entries 1 and 2 (the delay registers) are read
//                     back after writing; a mismatch sets errOut and the write+read
//                     is retried once before moving on.
//
// States
//   state       | meaning
//   S_IDLE      | waiting for lockedIn, PHY held in reset
//   S_RST_HOLD  | phyRstBOut low for RST_HOLD_CYC
//   S_RST_WAIT  | phyRstBOut high, settle for RST_WAIT_CYC
//   S_WR        | write frame for table entry idx_q
//   S_RD        | read frame (BMSR poll, or readback of entry idx_q)
//   S_GAP       | inter-frame idle, then dispatch to after_q
//   S_POLL_WAIT | POLL_CYC wait before the next BMSR read

module mdio_phy_cfg #(
  parameter int unsigned CLK_DIV      = 25,
  parameter logic [4:0]  PHY_ADDR     = 5'h01,
  parameter int unsigned RST_HOLD_CYC = 1250000,
  parameter int unsigned RST_WAIT_CYC = 6250000,
  parameter int unsigned POLL_CYC     = 12500000
) (
  input  logic clkIn,
  input  logic rstBIn,
  input  logic lockedIn,
  input  logic restartIn,
  output logic phyRstBOut,
  output logic mdClkOut,
  output logic mdioOut,
  output logic mdioOeOut,
  input  logic mdioIn,
  output logic cfgDoneOut,
  output logic linkUpOut,
  output logic errOut
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_HOLD, S_RST_WAIT, S_WR, S_RD, S_GAP, S_POLL_WAIT
  } state_t;

  localparam logic [15:0] DIV_LD  = 16'(CLK_DIV - 1);
  localparam logic [31:0] HOLD_LD = 32'(RST_HOLD_CYC - 1);
  localparam logic [31:0] WAIT_LD = 32'(RST_WAIT_CYC - 1);
  localparam logic [31:0] POLL_LD = 32'(POLL_CYC - 1);
  localparam logic [31:0] GAP_LD  = 32'(2 * CLK_DIV - 1);

  function automatic logic [4:0] rom_reg(input logic [1:0] i);
    case (i)
      2'd1:    rom_reg = 5'h11;
      2'd2:    rom_reg = 5'h15;
      default: rom_reg = 5'h1F;
    endcase
  endfunction

  function automatic logic [15:0] rom_data(input logic [1:0] i);
    case (i)
      2'd0:    rom_data = 16'h0D08;
      2'd1:    rom_data = 16'h0109;
      2'd2:    rom_data = 16'h0019;
      default: rom_data = 16'h0000;
    endcase
  endfunction

  state_t      state_q, after_q;
  logic [31:0] timer_q;
  logic [15:0] div_q;
  logic [5:0]  bit_q;
  logic [1:0]  idx_q;
  logic        verify_q;
  logic        link_smp_q;
  logic        mdc_q, mdio_q, oe_q;
  logic        phy_rst_b_q, cfg_done_q, link_q, err_q;
`ifdef MDIO_READBACK_EN
  logic [15:0] rd_data_q;
  logic        retry_q;
`endif

  logic [4:0]  cur_reg_d;
  logic [63:0] frame_word_d;
  logic        nxt_bit_d, nxt_oe_d;

  always_comb begin
    cur_reg_d = 5'h01;
    if (state_q == S_WR || verify_q) cur_reg_d = rom_reg(idx_q);
    if (state_q == S_RD)
      frame_word_d = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, cur_reg_d, 2'b11, 16'hFFFF};
    else
      frame_word_d = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, cur_reg_d, 2'b10, rom_data(idx_q)};
    nxt_bit_d = frame_word_d[6'd62 - bit_q];
    // read frames release the line from the first TA bit (bit 46) onwards
    nxt_oe_d  = (state_q == S_WR) || (bit_q < 6'd45);
  end

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state_q     <= S_IDLE;
      after_q     <= S_IDLE;
      timer_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      idx_q       <= '0;
      verify_q    <= 1'b0;
      link_smp_q  <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
      phy_rst_b_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      link_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MDIO_READBACK_EN
      rd_data_q   <= '0;
      retry_q     <= 1'b0;
`endif
    end else if (!lockedIn || restartIn) begin
      // abort anything in flight; lock loss parks in IDLE, restart reruns reset
      state_q     <= lockedIn ? S_RST_HOLD : S_IDLE;
      timer_q     <= HOLD_LD;
      idx_q       <= '0;
      verify_q    <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
      phy_rst_b_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      link_q      <= 1'b0;
`ifdef MDIO_READBACK_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_RST_HOLD;
          timer_q     <= HOLD_LD;
          phy_rst_b_q <= 1'b0;
        end

        S_RST_HOLD: begin
          if (timer_q == '0) begin
            state_q     <= S_RST_WAIT;
            timer_q     <= WAIT_LD;
            phy_rst_b_q <= 1'b1;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end

        S_RST_WAIT: begin
          if (timer_q == '0) begin
            state_q  <= S_WR;
            idx_q    <= '0;
            verify_q <= 1'b0;
            bit_q    <= '0;
            div_q    <= DIV_LD;
            mdc_q    <= 1'b0;
            oe_q     <= 1'b1;
            mdio_q   <= 1'b1;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end

        S_WR, S_RD: begin
          if (div_q != '0) begin
            div_q <= div_q - 16'd1;
          end else begin
            div_q <= DIV_LD;
            mdc_q <= ~mdc_q;
            if (!mdc_q) begin
              // MDC rises on this edge: sample the PHY's bit
              if (state_q == S_RD) begin
                if (bit_q == 6'd47 && mdioIn) err_q <= 1'b1;
                if (bit_q == 6'd61) link_smp_q <= mdioIn;
`ifdef MDIO_READBACK_EN
                if (bit_q >= 6'd48) rd_data_q <= {rd_data_q[14:0], mdioIn};
`endif
              end
            end else if (bit_q != 6'd63) begin
              bit_q  <= bit_q + 6'd1;
              oe_q   <= nxt_oe_d;
              mdio_q <= nxt_oe_d ? nxt_bit_d : 1'b1;
            end else begin
              // last falling edge: frame complete, decide what follows the gap
              oe_q    <= 1'b0;
              mdio_q  <= 1'b1;
              state_q <= S_GAP;
              timer_q <= GAP_LD;
              if (state_q == S_RD && !verify_q) begin
                link_q  <= link_smp_q;
                after_q <= S_POLL_WAIT;
              end
`ifdef MDIO_READBACK_EN
              else if (state_q == S_WR && (idx_q == 2'd1 || idx_q == 2'd2)) begin
                verify_q <= 1'b1;
                after_q  <= S_RD;
              end else if (state_q == S_RD && rd_data_q != rom_data(idx_q) && !retry_q) begin
                verify_q <= 1'b0;
                retry_q  <= 1'b1;
                err_q    <= 1'b1;
                after_q  <= S_WR;
              end
`endif
              else begin
`ifdef MDIO_READBACK_EN
                if (state_q == S_RD && rd_data_q != rom_data(idx_q)) err_q <= 1'b1;
                retry_q <= 1'b0;
`endif
                verify_q <= 1'b0;
                if (idx_q == 2'd3) begin
                  cfg_done_q <= 1'b1;
                  after_q    <= S_POLL_WAIT;
                end else begin
                  idx_q   <= idx_q + 2'd1;
                  after_q <= S_WR;
                end
              end
            end
          end
        end

        S_GAP: begin
          if (timer_q == '0) begin
            if (after_q == S_POLL_WAIT) begin
              state_q <= S_POLL_WAIT;
              timer_q <= POLL_LD;
            end else begin
              state_q <= after_q;
              bit_q   <= '0;
              div_q   <= DIV_LD;
              mdc_q   <= 1'b0;
              oe_q    <= 1'b1;
              mdio_q  <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end

        S_POLL_WAIT: begin
          if (timer_q == '0) begin
            state_q <= S_RD;
            bit_q   <= '0;
            div_q   <= DIV_LD;
            mdc_q   <= 1'b0;
            oe_q    <= 1'b1;
            mdio_q  <= 1'b1;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign phyRstBOut = phy_rst_b_q;
  assign mdClkOut   = mdc_q;
  assign mdioOut    = mdio_q;
  assign mdioOeOut  = oe_q;
  assign cfgDoneOut = cfg_done_q;
  assign linkUpOut  = link_q;
  assign errOut     = err_q;

endmodule
